// File: rtl/mips_core_pkg.sv
// Shared memory-stage types: completion event carried through the
// per-channel completion FIFOs and the write-back/commit output register.
package mips_core_pkg;

  localparam int unsigned MC_AL_ID_W = 6;
  localparam int unsigned MC_REG_W   = 6;
  localparam int unsigned MC_DATA_W  = 32;

  typedef struct packed {
    logic                  is_load;
    logic                  uses_rw;
    logic [MC_REG_W-1:0]   rw_addr;
    logic [MC_DATA_W-1:0]  rw_data;
    logic [MC_AL_ID_W-1:0] al_id;
  } mem_completion_t;

  // A completion writes the register file only for loads that target a register.
  function automatic logic wb_fire(input mem_completion_t e);
    return e.is_load & e.uses_rw;
  endfunction

endpackage

// File: rtl/completion_fifo.sv
// Single-channel completion FIFO: DEPTH entries (power of 2), wrapping
// pointers, occupancy count 0..DEPTH, synchronous flush and reset.
module completion_fifo
  import mips_core_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = mem_completion_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  entry_t                   push_data,
  input  logic                     pop,
  output entry_t                   head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;

  // Pointer and occupancy tracking; push and pop may coincide.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Entry storage; no reset needed since count gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Head entry and full flag.
  always_comb begin
    head = mem[rd_ptr];
    full = (count == CNT_W'(DEPTH));
  end

endmodule

// File: rtl/mem_completion_arbiter.sv
// Memory completion arbiter: NUM_CH completion channels buffered in
// per-channel FIFOs, granted round-robin (one per cycle) into a registered
// write-back/commit output with backpressure.
// Optional macro MEM_ARB_BYPASS_EN: an event arriving at an empty channel may
// be granted directly into the output register in the same cycle.
module mem_completion_arbiter
  import mips_core_pkg::*;
#(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned AL_ID_W = MC_AL_ID_W,
  parameter int unsigned REG_W   = MC_REG_W,
  parameter int unsigned DATA_W  = MC_DATA_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_flush,
  input  logic [NUM_CH-1:0]           i_ch_valid,
  output logic [NUM_CH-1:0]           o_ch_ready,
  input  logic [NUM_CH-1:0]           i_ch_is_load,
  input  logic [NUM_CH-1:0]           i_ch_uses_rw,
  input  logic [NUM_CH*REG_W-1:0]     i_ch_rw_addr,
  input  logic [NUM_CH*DATA_W-1:0]    i_ch_rw_data,
  input  logic [NUM_CH*AL_ID_W-1:0]   i_ch_al_id,
  output logic                        o_wb_valid,
  output logic [REG_W-1:0]            o_wb_rw_addr,
  output logic [DATA_W-1:0]           o_wb_rw_data,
  output logic                        o_commit_valid,
  output logic [AL_ID_W-1:0]          o_commit_al_id,
  input  logic                        i_out_ready
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned RR_W  = $clog2(NUM_CH);

  mem_completion_t   in_evt [NUM_CH];
  mem_completion_t   head   [NUM_CH];
  logic [CNT_W-1:0]  count  [NUM_CH];
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] bypass;

  logic [RR_W-1:0]   rr_ptr;
  logic [RR_W-1:0]   grant_idx;
  logic              grant_found;
  logic              grant_valid;
  logic              out_free;
  mem_completion_t   sel_evt;

  // Unpack the flat channel buses into per-channel events.
  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      in_evt[c].is_load = i_ch_is_load[c];
      in_evt[c].uses_rw = i_ch_uses_rw[c];
      in_evt[c].rw_addr = i_ch_rw_addr[c*REG_W +: REG_W];
      in_evt[c].rw_data = i_ch_rw_data[c*DATA_W +: DATA_W];
      in_evt[c].al_id   = i_ch_al_id[c*AL_ID_W +: AL_ID_W];
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    completion_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (mem_completion_t)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (i_flush),
      .push      (push[g]),
      .push_data (in_evt[g]),
      .pop       (pop[g]),
      .head      (head[g]),
      .count     (count[g]),
      .full      (full[g])
    );
  end

  // Channel ready and request vectors.
  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      o_ch_ready[c] = !rst && !full[c];
`ifdef MEM_ARB_BYPASS_EN
      req[c] = (count[c] != '0) || ((count[c] == '0) && i_ch_valid[c]);
`else
      req[c] = (count[c] != '0);
`endif
    end
  end

  // Round-robin search starting at rr_ptr, ascending, wrapping at NUM_CH.
  always_comb begin
    int unsigned idx;
    logic [RR_W-1:0] sel;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      sel = RR_W'(idx);
      if (!grant_found && req[sel]) begin
        grant_found = 1'b1;
        grant_idx   = sel;
      end
    end
    out_free    = !o_commit_valid || i_out_ready;
    grant_valid = grant_found && out_free && !i_flush && !rst;
  end

  // FIFO push/pop control and selection of the granted event.
  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      bypass[c] = 1'b0;
`ifdef MEM_ARB_BYPASS_EN
      bypass[c] = grant_valid && (grant_idx == RR_W'(c)) && (count[c] == '0);
`endif
      pop[c]  = grant_valid && (grant_idx == RR_W'(c)) && (count[c] != '0);
      push[c] = i_ch_valid[c] && o_ch_ready[c] && !i_flush && !bypass[c];
    end
`ifdef MEM_ARB_BYPASS_EN
    sel_evt = bypass[grant_idx] ? in_evt[grant_idx] : head[grant_idx];
`else
    sel_evt = head[grant_idx];
`endif
  end

  // Round-robin pointer advances past the granted channel.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      rr_ptr <= '0;
    end else if (grant_valid) begin
      rr_ptr <= (grant_idx == RR_W'(NUM_CH - 1)) ? '0 : grant_idx + RR_W'(1);
    end
  end

  // Output register: load on grant, clear when consumed, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      o_commit_valid <= 1'b0;
      o_commit_al_id <= '0;
      o_wb_valid     <= 1'b0;
      o_wb_rw_addr   <= '0;
      o_wb_rw_data   <= '0;
    end else if (grant_valid) begin
      o_commit_valid <= 1'b1;
      o_commit_al_id <= sel_evt.al_id;
      o_wb_valid     <= wb_fire(sel_evt);
      o_wb_rw_addr   <= sel_evt.is_load ? sel_evt.rw_addr : '0;
      o_wb_rw_data   <= sel_evt.is_load ? sel_evt.rw_data : '0;
    end else if (i_out_ready) begin
      o_commit_valid <= 1'b0;
      o_commit_al_id <= '0;
      o_wb_valid     <= 1'b0;
      o_wb_rw_addr   <= '0;
      o_wb_rw_data   <= '0;
    end
  end

endmodule

// File: tb/tb_mem_completion_arbiter.sv
// Scoreboard bench for mem_completion_arbiter (NUM_CH=2, DEPTH=4).
module tb_mem_completion_arbiter;

  localparam int unsigned NCH = 2;
  localparam int unsigned AW  = 6;
  localparam int unsigned RW  = 6;
  localparam int unsigned DW  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_flush;
  logic [NCH-1:0]    i_ch_valid;
  logic [NCH-1:0]    o_ch_ready;
  logic [NCH-1:0]    i_ch_is_load;
  logic [NCH-1:0]    i_ch_uses_rw;
  logic [NCH*RW-1:0] i_ch_rw_addr;
  logic [NCH*DW-1:0] i_ch_rw_data;
  logic [NCH*AW-1:0] i_ch_al_id;
  logic              o_wb_valid;
  logic [RW-1:0]     o_wb_rw_addr;
  logic [DW-1:0]     o_wb_rw_data;
  logic              o_commit_valid;
  logic [AW-1:0]     o_commit_al_id;
  logic              i_out_ready;

  always #5 clk = ~clk;

  mem_completion_arbiter #(
    .NUM_CH  (NCH),
    .DEPTH   (4),
    .AL_ID_W (AW),
    .REG_W   (RW),
    .DATA_W  (DW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_flush        (i_flush),
    .i_ch_valid     (i_ch_valid),
    .o_ch_ready     (o_ch_ready),
    .i_ch_is_load   (i_ch_is_load),
    .i_ch_uses_rw   (i_ch_uses_rw),
    .i_ch_rw_addr   (i_ch_rw_addr),
    .i_ch_rw_data   (i_ch_rw_data),
    .i_ch_al_id     (i_ch_al_id),
    .o_wb_valid     (o_wb_valid),
    .o_wb_rw_addr   (o_wb_rw_addr),
    .o_wb_rw_data   (o_wb_rw_data),
    .o_commit_valid (o_commit_valid),
    .o_commit_al_id (o_commit_al_id),
    .i_out_ready    (i_out_ready)
  );

  typedef struct {
    logic          wb_valid;
    logic [RW-1:0] addr;
    logic [DW-1:0] data;
    logic [AW-1:0] id;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic auto_exp  = 1'b1;
  logic b2b_check = 1'b0;
  logic have_last = 1'b0;
  int   last_cyc  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every transfer (valid & ready, not flushed) pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && i_flush === 1'b0 && o_commit_valid === 1'b1 && i_out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got al_id %0d expected none", o_commit_al_id);
      end else begin
        e = exp_q.pop_front();
        check("commit_al_id", 64'(o_commit_al_id), 64'(e.id));
        check("wb_valid", 64'(o_wb_valid), 64'(e.wb_valid));
        check("wb_rw_addr", 64'(o_wb_rw_addr), 64'(e.addr));
        check("wb_rw_data", 64'(o_wb_rw_data), 64'(e.data));
      end
      if (b2b_check) begin
        if (have_last) check("back_to_back_gap", 64'(cyc - last_cyc), 64'd1);
        have_last = 1'b1;
        last_cyc  = cyc;
      end
    end
  end

  task automatic set_ch(input int c, input logic v, input logic ld, input logic uw,
                        input logic [RW-1:0] a, input logic [DW-1:0] d, input logic [AW-1:0] id);
    i_ch_valid[c]           = v;
    i_ch_is_load[c]         = ld;
    i_ch_uses_rw[c]         = uw;
    i_ch_rw_addr[c*RW +: RW] = a;
    i_ch_rw_data[c*DW +: DW] = d;
    i_ch_al_id[c*AW +: AW]   = id;
  endtask

  // One clock: note which channels transfer, record expectations, advance.
  task automatic step(output logic [NCH-1:0] acc);
    acc = i_ch_valid & o_ch_ready & {NCH{~i_flush & ~rst}};
    for (int c = 0; c < int'(NCH); c++) begin
      if (auto_exp && acc[c]) begin
        exp_t e;
        e.wb_valid = i_ch_is_load[c] & i_ch_uses_rw[c];
        e.addr     = i_ch_is_load[c] ? i_ch_rw_addr[c*RW +: RW] : '0;
        e.data     = i_ch_is_load[c] ? i_ch_rw_data[c*DW +: DW] : '0;
        e.id       = i_ch_al_id[c*AW +: AW];
        exp_q.push_back(e);
      end
    end
    if (i_flush) exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic chk);
    logic [NCH-1:0] acc;
    rst          = 1'b1;
    i_flush      = 1'b0;
    i_out_ready  = 1'b1;
    i_ch_valid   = '0;
    i_ch_is_load = '0;
    i_ch_uses_rw = '0;
    i_ch_rw_addr = '0;
    i_ch_rw_data = '0;
    i_ch_al_id   = '0;
    for (int i = 0; i < 2; i++) begin
      step(acc);
      if (chk) begin
        check("rst_ctrl_outputs", 64'({o_wb_valid, o_commit_valid, o_commit_al_id, o_wb_rw_addr}), 64'd0);
        check("rst_wb_data", 64'(o_wb_rw_data), 64'd0);
        check("rst_ch_ready", 64'(o_ch_ready), 64'd0);
      end
    end
    rst = 1'b0;
    exp_q.delete();
    step(acc);
    if (chk) check("ready_after_rst", 64'(o_ch_ready), 64'b11);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NCH-1:0] acc;
    int n0, n1, nid;

    // Reset behaviour.
    do_reset(1'b1);

    // Single load on ch0; latency checked directly, fields by the monitor.
    set_ch(0, 1'b1, 1'b1, 1'b1, 6'd12, 32'hDEADBEEF, 6'd5);
    step(acc);
    check("load_accepted", 64'(acc), 64'b01);
    i_ch_valid = '0;
`ifdef MEM_ARB_BYPASS_EN
    check("load_visible_n1", 64'({o_commit_valid, o_wb_valid}), 64'b11);
`else
    check("load_hidden_n1", 64'(o_commit_valid), 64'd0);
    step(acc);
    check("load_visible_n2", 64'({o_commit_valid, o_wb_valid}), 64'b11);
`endif
    step(acc);
    step(acc);

    // Store on ch1: commit only, write-back fields zero.
    set_ch(1, 1'b1, 1'b0, 1'b1, 6'd7, 32'h0000_1234, 6'd9);
    step(acc);
    i_ch_valid = '0;
    for (int i = 0; i < 3; i++) step(acc);
    check("single_drained", 64'(exp_q.size()), 64'd0);

    // Both channels streaming with output always ready: strict alternation.
    do_reset(1'b0);
    auto_exp = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back('{1'b1, 6'(10 + k), 32'(32'h100 + 10 + k), 6'(10 + k)});
      exp_q.push_back('{1'b0, 6'd0, 32'd0, 6'(20 + k)});
    end
    have_last = 1'b0;
    b2b_check = 1'b1;
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 14; i++) begin
      set_ch(0, n0 < 4, 1'b1, 1'b1, 6'(10 + n0), 32'(32'h100 + 10 + n0), 6'(10 + n0));
      set_ch(1, n1 < 4, 1'b0, 1'b0, 6'd0, 32'd0, 6'(20 + n1));
      step(acc);
      n0 += int'(acc[0]);
      n1 += int'(acc[1]);
    end
    b2b_check = 1'b0;
    auto_exp  = 1'b1;
    i_ch_valid = '0;
    check("alt_drained", 64'(exp_q.size()), 64'd0);

    // Backpressure: output stalls on id 1, ch0 FIFO fills after 4 enqueues.
    do_reset(1'b0);
    i_out_ready = 1'b0;
    nid = 1;
    for (int i = 0; i < 8; i++) begin
      set_ch(0, 1'b1, 1'b1, 1'b1, 6'(nid), 32'(32'hA0 + nid), 6'(nid));
      step(acc);
      if (acc[0]) nid++;
      if (i >= 1) check("hold_id1", 64'({o_commit_valid, o_commit_al_id}), 64'({1'b1, 6'd1}));
      if (i == 3) check("ready_before_full", 64'(o_ch_ready[0]), 64'd1);
      if (i == 4) check("ready_at_full", 64'(o_ch_ready[0]), 64'd0);
    end
    check("bp_accepted", 64'(nid - 1), 64'd5);
    i_ch_valid  = '0;
    i_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) step(acc);
    check("bp_drained", 64'(exp_q.size()), 64'd0);

    // Flush with buffered events; the flush-cycle input is dropped.
    do_reset(1'b0);
    i_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_ch(0, 1'b1, 1'b1, 1'b1, 6'(i), 32'(32'h300 + i), 6'(30 + i));
      step(acc);
    end
    set_ch(0, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 6'd0);
    set_ch(1, 1'b1, 1'b1, 1'b1, 6'd3, 32'h55, 6'd40);
    i_flush = 1'b1;
    step(acc);
    i_flush    = 1'b0;
    i_ch_valid = '0;
    check("flush_out_cleared", 64'({o_commit_valid, o_wb_valid}), 64'd0);
    check("flush_ready", 64'(o_ch_ready), 64'b11);
    i_out_ready = 1'b1;
    for (int i = 0; i < 6; i++) step(acc);
    set_ch(1, 1'b1, 1'b1, 1'b1, 6'd50, 32'hCAFE_0050, 6'd50);
    step(acc);
    i_ch_valid = '0;
    for (int i = 0; i < 4; i++) step(acc);
    check("post_flush_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_completion_arbiter.md
# mem_completion_arbiter

Parametrised memory completion arbiter for the memory stage. Collects completion events from NUM_CH memory channels (load ports, store ports, store-to-load bypass) into per-channel FIFOs. One event per cycle is granted round-robin into a registered write-back/commit output with backpressure. Supersedes the single-channel combinational load/store selection.

## Interface
- NUM_CH, 2, number of completion channels (≥2)
- DEPTH, 4, entries per channel FIFO (power of 2, ≥2)
- AL_ID_W, 6, active-list id width
- REG_W, 6, physical register address width
- DATA_W, 32, write-back data width
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- i_flush  in  1  synchronous squash of all buffered and output state
- i_ch_valid  in  NUM_CH  channel c presents an event
- o_ch_ready  out  NUM_CH  channel c accepts; an event transfers when valid & ready
- i_ch_is_load  in  NUM_CH  1 = load (write-back + commit), 0 = store (commit only)
- i_ch_uses_rw  in  NUM_CH  load writes a register
- i_ch_rw_addr  in  NUM_CH×REG_W  destination physical register
- i_ch_rw_data  in  NUM_CH×DATA_W  load data
- i_ch_al_id  in  NUM_CH×AL_ID_W  active-list id
- o_wb_valid  out  1  write-back valid (load with uses_rw)
- o_wb_rw_addr  out  REG_W  write-back register
- o_wb_rw_data  out  DATA_W  write-back data
- o_commit_valid  out  1  completion event valid
- o_commit_al_id  out  AL_ID_W  completing active-list id
- i_out_ready  in  1  consumer accepts the output event this cycle

## Operation
- Per-channel FIFO: count 0..DEPTH, wrapping read/write pointers of log2(DEPTH) bits; enqueue on i_ch_valid & o_ch_ready.
- o_ch_ready[c] = !rst & (count[c] != DEPTH). Full with a simultaneous dequeue still reports not ready.
- Request[c] = count[c] != 0.
- Round-robin grant: first requesting channel starting at rr_ptr, ascending, mod NUM_CH. On grant, rr_ptr <= granted+1 mod NUM_CH. rr_ptr holds when nothing is granted.
- Grant issued only when output register is free (!o_commit_valid | i_out_ready). The granted FIFO head dequeues the same cycle.
- Simultaneous enqueue and dequeue on one channel: count unchanged; pointers both advance.
- Output register: o_commit_valid/o_commit_al_id from granted entry. o_wb_valid = is_load & uses_rw, with addr and data. Stores force wb fields to 0.
- Output holds stable while o_commit_valid & !i_out_ready.
- i_flush: all counts, pointers, and rr_ptr cleared; output register cleared. Inputs in the flush cycle are dropped, and i_out_ready is ignored. Flush has priority over enqueue/grant; rst has priority over flush.
- Reset: all outputs 0; counts 0; rr_ptr 0; o_ch_ready 0 during rst, all 1 the cycle after.

## Timing
- Base latency: event accepted in cycle N enters FIFO. It is granted in N+1 at earliest and visible on outputs in N+2.
- Throughput: one event per cycle sustained when i_out_ready held high.
- Fairness: a requesting channel is granted within NUM_CH grants.
- Backpressure: with i_out_ready low, FIFOs fill; o_ch_ready drops the cycle after count reaches DEPTH.

## Configuration
- MEM_ARB_BYPASS_EN defined: Request[c] also asserted when count[c]==0 & i_ch_valid[c]. If that channel is granted, the input event goes directly to the output register without entering the FIFO. Latency 1 (visible N+1).
- Undefined: no bypass path; latency 2 always. Grant order is identical under both settings for the same request set.

## Structure
- Shared package mips_core_pkg gains typedef mem_completion_t {is_load, uses_rw, rw_addr, rw_data, al_id}, used as the FIFO entry and output register type.
- Sub-module: completion_fifo (one instance per channel; DEPTH, entry type; push/pop/count/head, synchronous flush).
- Arbiter and output register live in the top module.

## Test plan
- Reset: assert rst 2 cycles → all outputs 0, o_ch_ready=0; cycle after release o_ch_ready=2'b11.
- Single load ch0, al_id=5, rw_addr=12, data=0xDEADBEEF, uses_rw=1 at cycle N → o_wb_valid & o_commit_valid at N+2 (N+1 with MEM_ARB_BYPASS_EN), fields match.
- Store ch1 al_id=9 → o_commit_valid with al_id=9, o_wb_valid=0, o_wb_rw_data=0.
- Both channels valid every cycle, i_out_ready=1 → commit ids alternate ch0,ch1,ch0,…; one event per cycle.
- i_out_ready=0 for 8 cycles with ch0 streaming al_id 1..8 → output holds id 1. o_ch_ready[0] drops after DEPTH=4 enqueues. After release, ids 1–5 emerge in order; none lost.
- Three events buffered, i_flush pulse → next cycle all counts 0, o_commit_valid=0. Events enqueued in the flush cycle never appear.
